// File: rtl/rtc_scan_sequencer.sv
// RTC scan sequencer: reads the six BCD time fields (seconds..year) from the
// RTC controller one after another. For each field it writes the register
// address, issues a read command, waits for flag_done (bounded by TIMEOUT),
// then strobes the result out of the controller and latches it.
module rtc_scan_sequencer #(
  parameter logic [7:0] BASE_ADDR = 8'h21,
  parameter logic [7:0] TIMEOUT   = 8'd200,
  parameter logic [7:0] IDLE_PORT = 8'hFF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic [7:0] port_id,
  output logic [7:0] out_port,
  output logic       write_strobe,
  output logic       read_strobe,
  input  logic [7:0] in_port,
  input  logic       flag_done,
  output logic [7:0] seconds,
  output logic [7:0] minutes,
  output logic [7:0] hours,
  output logic [7:0] day,
  output logic [7:0] month,
  output logic [7:0] year,
  output logic       busy,
  output logic       data_valid,
  output logic       timeout_err
);

  typedef enum logic [2:0] {
    IDLE, SET_ADDR, START_RD, WAIT_DONE, ACK, NEXT, FINISH
  } state_t;

  state_t     state;
  logic [2:0] idx;
  logic [7:0] cnt;

  // Single FSM; bus outputs are registered and loaded for the state being
  // entered, so they are valid for exactly the cycle spent in that state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      idx          <= 3'd0;
      cnt          <= 8'd0;
      port_id      <= IDLE_PORT;
      out_port     <= 8'h00;
      write_strobe <= 1'b0;
      read_strobe  <= 1'b0;
      seconds      <= 8'h00;
      minutes      <= 8'h00;
      hours        <= 8'h00;
      day          <= 8'h00;
      month        <= 8'h00;
      year         <= 8'h00;
      busy         <= 1'b0;
      data_valid   <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      // Quiet bus unless the next state drives it.
      port_id      <= IDLE_PORT;
      out_port     <= 8'h00;
      write_strobe <= 1'b0;
      read_strobe  <= 1'b0;
      data_valid   <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            idx          <= 3'd0;
            timeout_err  <= 1'b0;
            busy         <= 1'b1;
            state        <= SET_ADDR;
            port_id      <= 8'h00;
            out_port     <= BASE_ADDR;
            write_strobe <= 1'b1;
          end
        end
        SET_ADDR: begin
          state        <= START_RD;
          port_id      <= 8'h0E;
          out_port     <= 8'h00;
          write_strobe <= 1'b1;
        end
        START_RD: begin
          cnt   <= 8'd0;
          state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          cnt <= cnt + 8'd1;
          // A completion arriving on the last allowed cycle still wins.
          if (flag_done) begin
            state       <= ACK;
            port_id     <= 8'h0F;
            read_strobe <= 1'b1;
          end else if (cnt == TIMEOUT - 8'd1) begin
            state       <= IDLE;
            timeout_err <= 1'b1;
            busy        <= 1'b0;
          end
        end
        ACK: begin
          case (idx)
            3'd0:    seconds <= in_port;
            3'd1:    minutes <= in_port;
            3'd2:    hours   <= in_port;
            3'd3:    day     <= in_port;
            3'd4:    month   <= in_port;
            default: year    <= in_port;
          endcase
          state <= NEXT;
        end
        NEXT: begin
          if (idx == 3'd5) begin
            state      <= FINISH;
            data_valid <= 1'b1;
          end else begin
            idx          <= idx + 3'd1;
            state        <= SET_ADDR;
            port_id      <= 8'h00;
            out_port     <= BASE_ADDR + {5'd0, idx} + 8'd1;
            write_strobe <= 1'b1;
          end
        end
        FINISH: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rtc_scan_sequencer.sv
// Bench for rtc_scan_sequencer: a behavioural RTC controller answers each
// read after a programmable number of wait cycles; table-driven scans plus
// hand-written timeout, start-while-busy and mid-scan reset sequences.
module tb_rtc_scan_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] port_id, out_port;
  logic       write_strobe, read_strobe;
  logic [7:0] in_port = 8'h00;
  logic       flag_done = 1'b0;
  logic [7:0] seconds, minutes, hours, day, month, year;
  logic       busy, data_valid, timeout_err;

  rtc_scan_sequencer dut (
    .clk(clk), .reset(reset), .start(start),
    .port_id(port_id), .out_port(out_port),
    .write_strobe(write_strobe), .read_strobe(read_strobe),
    .in_port(in_port), .flag_done(flag_done),
    .seconds(seconds), .minutes(minutes), .hours(hours),
    .day(day), .month(month), .year(year),
    .busy(busy), .data_valid(data_valid), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] s, mi, h, dy, mo, y;  // RTC contents served, expected in fields
    int         w;                    // WAIT_DONE cycles before flag_done
    int         lat;                  // expected start-to-data_valid edges
  } vec_t;

  int compared   = 0;
  int mismatched = 0;

  // Controller model configuration (written by the test process only)
  logic [7:0] resp_data [6];
  int         resp_w     = 3;
  int         hang_field = -1;

  // Controller model state (written by the responder only)
  int wcnt      = -1;
  int cur_field = 0;

  // Protocol tracking (written by the test process only)
  int mon_field = 0;
  int dv_cnt    = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural controller: raises flag_done in the resp_w-th WAIT_DONE cycle
  // with the field data on in_port, holds both until the read strobe.
  always @(negedge clk) begin
    if (reset) begin
      wcnt      <= -1;
      flag_done <= 1'b0;
    end else if (write_strobe && port_id == 8'h00) begin
      cur_field <= int'(out_port - 8'h21);
    end else if (write_strobe && port_id == 8'h0E) begin
      wcnt      <= 0;
      flag_done <= 1'b0;
    end else if (read_strobe) begin
      wcnt      <= -1;
      flag_done <= 1'b0;
    end else if (wcnt >= 0) begin
      wcnt <= wcnt + 1;
      if (wcnt + 1 == resp_w && cur_field != hang_field && cur_field >= 0 && cur_field < 6) begin
        flag_done <= 1'b1;
        in_port   <= resp_data[cur_field];
      end
    end
  end

  // Per-cycle bus protocol check, called right after each falling edge.
  task automatic mon_step();
    chk("one_strobe", 32'(write_strobe) + 32'(read_strobe) <= 1, 32'd1);
    if (!busy) mon_field = 0;
    if (write_strobe && port_id == 8'h00) begin
      chk("set_addr_out", out_port, 32'(8'(8'h21 + mon_field)));
      mon_field++;
    end else if (write_strobe) begin
      chk("start_rd_port", port_id, 8'h0E);
      chk("start_rd_out", out_port, 8'h00);
    end else if (read_strobe) begin
      chk("ack_port", port_id, 8'h0F);
      chk("ack_out", out_port, 8'h00);
    end else begin
      chk("idle_port", port_id, 8'hFF);
      chk("idle_out", out_port, 8'h00);
    end
    if (data_valid) dv_cnt++;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_port_id"}, port_id, 8'hFF);
    chk({tag, "_out_port"}, out_port, 8'h00);
    chk({tag, "_strobes"}, {write_strobe, read_strobe}, 2'b00);
    chk({tag, "_fields"}, {seconds, minutes, hours, day, month, year}, 48'h0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_data_valid"}, data_valid, 1'b0);
    chk({tag, "_timeout_err"}, timeout_err, 1'b0);
  endtask

  // Pulse start, then step until data_valid or busy drops; n = edges from
  // (and including) the edge that sampled start. inject>0 re-pulses start.
  task automatic run_scan(input vec_t v, input int hang, input int inject, output int n);
    resp_data[0] = v.s;  resp_data[1] = v.mi; resp_data[2] = v.h;
    resp_data[3] = v.dy; resp_data[4] = v.mo; resp_data[5] = v.y;
    resp_w = v.w;
    hang_field = hang;
    dv_cnt = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    mon_step();
    chk("busy_after_start", busy, 1'b1);
    chk("terr_cleared_on_start", timeout_err, 1'b0);
    while (!data_valid && busy && n < 1000) begin
      if (n == inject) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n++;
      mon_step();
    end
    if (n >= 1000) chk("scan_bound", 0, 1);
  endtask

  task automatic check_done(input string tag, input vec_t v, input int n);
    chk({tag, "_latency"}, n, v.lat);
    chk({tag, "_dv_high"}, data_valid, 1'b1);
    chk({tag, "_busy_in_finish"}, busy, 1'b1);
    chk({tag, "_fields"}, {seconds, minutes, hours, day, month, year},
        {v.s, v.mi, v.h, v.dy, v.mo, v.y});
    @(negedge clk);
    mon_step();
    chk({tag, "_busy_fell"}, busy, 1'b0);
    chk({tag, "_dv_fell"}, data_valid, 1'b0);
    chk({tag, "_dv_count"}, dv_cnt, 1);
    chk({tag, "_timeout_err"}, timeout_err, 1'b0);
  endtask

  vec_t vecs [4];
  vec_t vt;
  int   n;
  int   acks;

  initial begin
    vecs[0] = '{s:8'h45, mi:8'h59, h:8'h23, dy:8'h31, mo:8'h12, y:8'h17, w:3, lat:43};
    vecs[1] = '{s:8'h00, mi:8'h00, h:8'h00, dy:8'h01, mo:8'h01, y:8'h00, w:1, lat:31};
    vecs[2] = '{s:8'h59, mi:8'h59, h:8'h23, dy:8'h28, mo:8'h02, y:8'h99, w:5, lat:55};
    vecs[3] = '{s:8'h30, mi:8'h15, h:8'h08, dy:8'h15, mo:8'h06, y:8'h24, w:2, lat:37};
    vt      = '{s:8'hAA, mi:8'hBB, h:8'hCC, dy:8'hDD, mo:8'hEE, y:8'hFF, w:3, lat:0};

    reset = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    reset = 1'b0;
    @(negedge clk);
    mon_step();

    // Nominal scans from the table
    for (int i = 0; i < 4; i++) begin
      run_scan(vecs[i], -1, 0, n);
      check_done($sformatf("vec%0d", i), vecs[i], n);
      repeat (2) begin @(negedge clk); mon_step(); end
    end

    // Field 2 never completes: abort after 200 WAIT_DONE cycles
    run_scan(vt, 2, 0, n);
    chk("to_idle_edge", n, 217);
    chk("to_err", timeout_err, 1'b1);
    chk("to_busy", busy, 1'b0);
    chk("to_no_dv", dv_cnt, 0);
    chk("to_sec_min", {seconds, minutes}, {vt.s, vt.mi});
    chk("to_kept", {hours, day, month, year}, {vecs[3].h, vecs[3].dy, vecs[3].mo, vecs[3].y});
    repeat (3) begin @(negedge clk); mon_step(); end
    chk("to_err_sticky", timeout_err, 1'b1);

    // New start clears the error; extra start during WAIT_DONE is ignored
    run_scan(vecs[0], -1, 10, n);
    check_done("restart", vecs[0], n);
    repeat (8) begin @(negedge clk); mon_step(); end
    chk("no_queued_start", busy, 1'b0);

    // Reset during the ACK of field index 3, then a clean rescan
    resp_data[0] = vecs[3].s;  resp_data[1] = vecs[3].mi; resp_data[2] = vecs[3].h;
    resp_data[3] = vecs[3].dy; resp_data[4] = vecs[3].mo; resp_data[5] = vecs[3].y;
    resp_w = vecs[3].w;
    hang_field = -1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    mon_step();
    acks = 0;
    n = 1;
    while (acks < 4 && n < 200) begin
      @(negedge clk);
      n++;
      mon_step();
      if (read_strobe) acks++;
    end
    chk("rst_reached_ack3", acks, 4);
    reset = 1'b1;
    @(negedge clk);
    check_reset_values("midrst");
    reset = 1'b0;
    @(negedge clk);
    mon_step();
    run_scan(vecs[1], -1, 0, n);
    check_done("after_rst", vecs[1], n);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rtc_scan_sequencer.md
RTC_SCAN_SEQUENCER -- requirements
Module: rtc_scan_sequencer

Interface
REQ-001 Parameter BASE_ADDR, default 8'h21, RTC register address of the first scanned field (seconds).
REQ-002 Parameter TIMEOUT, default 8'd200, maximum clk cycles to wait for flag_done per field.
REQ-003 Parameter IDLE_PORT, default 8'hFF, port_id value driven when no access is in progress.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset; ports clk and reset are named as in the RTC controller.
REQ-005 clk  input  1  system clock; all state updates occur on posedge clk.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 start  input  1  single-cycle request to scan all six time fields.
REQ-008 port_id  output  8  peripheral select to the RTC controller.
REQ-009 out_port  output  8  address or command byte to the controller in_dato.
REQ-010 write_strobe  output  1  one-cycle write qualifier.
REQ-011 read_strobe  output  1  one-cycle read qualifier.
REQ-012 in_port  input  8  controller out_dato (RTC read data).
REQ-013 flag_done  input  1  controller completion flag (level).
REQ-014 seconds, minutes, hours, day, month, year  output  8 each  last captured BCD fields.
REQ-015 busy  output  1  high from the cycle after an accepted start until the scan ends.
REQ-016 data_valid  output  1  one-cycle pulse when all six fields are updated.
REQ-017 timeout_err  output  1  sticky error; cleared by the next accepted start.

Function
REQ-018 The FSM SHALL have states IDLE, SET_ADDR, START_RD, WAIT_DONE, ACK, NEXT, FINISH.
REQ-019 In IDLE, start=1 SHALL be accepted, field index idx cleared to 0, timeout_err cleared, next state SET_ADDR.
REQ-020 In SET_ADDR (one cycle): port_id=8'h00, out_port=BASE_ADDR+idx (8-bit wrap), write_strobe=1; next START_RD.
REQ-021 In START_RD (one cycle): port_id=8'h0E, out_port=8'h00 (read), write_strobe=1; timeout counter cleared; next WAIT_DONE.
REQ-022 In WAIT_DONE: port_id=IDLE_PORT, strobes 0; counter increments each cycle; flag_done=1 -> ACK; counter reaching TIMEOUT with flag_done=0 -> timeout_err=1, next IDLE, field registers unchanged for the aborted field.
REQ-023 flag_done=1 and timeout expiry in the same cycle SHALL resolve to ACK (no error).
REQ-024 In ACK (one cycle): port_id=8'h0F, read_strobe=1, in_port captured into field idx (0 sec, 1 min, 2 hr, 3 day, 4 month, 5 year); next NEXT.
REQ-025 In NEXT: idx=5 -> FINISH; else idx increments, next SET_ADDR.
REQ-026 In FINISH (one cycle): data_valid=1; next IDLE.
REQ-027 start while busy SHALL be ignored; it is not queued.
REQ-028 Outside SET_ADDR/START_RD/ACK, port_id SHALL equal IDLE_PORT, out_port 8'h00, both strobes 0.
REQ-029 busy SHALL be 0 only in IDLE.
REQ-030 Nominal scan latency: start to data_valid = 6*(4+W)+1 cycles, W = WAIT_DONE cycles per field before flag_done.

Reset
REQ-031 reset=1 at a clock edge SHALL force IDLE, idx=0, counter=0, all field outputs 8'h00, port_id=IDLE_PORT, out_port=8'h00, strobes 0, busy 0, data_valid 0, timeout_err 0, including mid-scan.

Verification
REQ-032 Reset then start, flag_done asserted 3 cycles into each WAIT_DONE, in_port = 8'h45,59,23,31,12,17 -> fields match, data_valid pulses once at cycle 6*7+1=43, busy falls with it.
REQ-033 Per field: SET_ADDR shows port_id 00/out_port 21..26 with write_strobe; START_RD shows 0E/00; ACK shows 0F with read_strobe; exactly one strobe per cycle.
REQ-034 flag_done held 0 on field 2 -> timeout_err=1 after 200 WAIT_DONE cycles, IDLE, hours/day/month/year unchanged, no data_valid.
REQ-035 start pulsed during WAIT_DONE -> ignored; single data_valid; new start after FINISH clears timeout_err and rescans.
REQ-036 reset asserted during field 3 ACK -> next cycle all outputs at reset values; subsequent start scans from BASE_ADDR.
